// File: rtl/ternary_pkg.sv
// Shared opcodes, state encoding and sizing helpers for the ternary matrix-vector engine.
package ternary_pkg;

    localparam logic [3:0] OP_LOAD    = 4'hA;
    localparam logic [3:0] OP_MULT    = 4'hF;
    localparam logic [3:0] OP_REDRAIN = 4'hB;
    localparam logic [3:0] OP_CLEAR   = 4'h5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MULT, S_DRAIN} state_t;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    localparam int ACT_W = 8;
    // Row/column counters hold 1..16, so one spare bit above a 4-bit index.
    localparam int CNT_W = 5;

    function automatic int acc_width(input int in_len);
        return ACT_W + $clog2(in_len) + 1;
    endfunction

endpackage

// File: rtl/ternary_acc_lane.sv
// One output row: ternary weights, two-term accumulate per beat, saturating readout.
module ternary_acc_lane
    import ternary_pkg::*;
#(
    parameter int IN_LEN = 16,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           load_en,
    input  logic [IN_LEN-1:0]              col_we,
    input  logic [IN_LEN-1:0][1:0]         col_code,
    input  logic                           mult_en,
    input  logic                           first,
    input  logic [CNT_W-1:0]               col,
    input  logic signed [ACT_W-1:0]        x0,
    input  logic signed [ACT_W-1:0]        x1,
    input  logic                           x1_en,
    output logic [OUT_W-1:0]               data,
    output logic                           sat
);

    localparam int SMAX_I = 2 ** (OUT_W - 1) - 1;
    localparam int SMIN_I = -(2 ** (OUT_W - 1));
    localparam logic signed [ACC_W-1:0] SMAX = SMAX_I[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] SMIN = SMIN_I[ACC_W-1:0];

    logic [IN_LEN-1:0][1:0]  w;
    logic signed [ACC_W-1:0] acc, base, t0, t1;
    logic [1:0]              wa, wb;

    function automatic logic signed [ACC_W-1:0] tmul(input logic [1:0] code,
                                                     input logic signed [ACT_W-1:0] x);
        logic signed [ACC_W-1:0] xe;
        xe = {{(ACC_W-ACT_W){x[ACT_W-1]}}, x};
        case (code)
            W_POS:   tmul = xe;
            W_NEG:   tmul = -xe;
            default: tmul = '0;
        endcase
    endfunction

    always_comb begin
        wa = W_ZERO;
        wb = W_ZERO;
        for (int c = 0; c < IN_LEN; c++) begin
            if (col == CNT_W'(c))              wa = w[c];
            if (col + CNT_W'(1) == CNT_W'(c))  wb = w[c];
        end
    end

    always_comb begin
        base = first ? '0 : acc;
        t0   = tmul(wa, x0);
        t1   = x1_en ? tmul(wb, x1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            w   <= '0;
            acc <= '0;
        end else begin
            if (load_en) begin
                for (int c = 0; c < IN_LEN; c++)
                    if (col_we[c]) w[c] <= col_code[c];
            end
            if (mult_en) acc <= base + t0 + t1;
        end
    end

    always_comb begin
        sat  = 1'b0;
        data = acc[OUT_W-1:0];
        if (acc > SMAX) begin
            sat  = 1'b1;
            data = SMAX[OUT_W-1:0];
        end else if (acc < SMIN) begin
            sat  = 1'b1;
            data = SMIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/ternary_mvm_engine.sv
// Command-driven ternary matrix-vector engine: opcode decode, weight load, MULT beats, DRAIN stream.
module ternary_mvm_engine
    import ternary_pkg::*;
#(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_word,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             err,
    output logic             sat_flag
);

    localparam int ACC_W = acc_width(IN_LEN);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUT_LEN);
    localparam logic [CNT_W-1:0] IN_MAX  = CNT_W'(IN_LEN);

    state_t           state;
    logic [CNT_W-1:0] n_out, n_in, row, beat, col, idx, bpr, req_out, req_in;
    logic [8:0]       n_vec;
    logic             auto_mult, redrain;
    logic             in_xfer, out_xfer, clear, first, x1_en, sel_sat;
    logic [OUT_W-1:0] sel_data;

    logic [OUT_LEN-1:0]            load_en, mult_en, lane_sat;
    logic [OUT_LEN-1:0][OUT_W-1:0] lane_data;
    logic [IN_LEN-1:0]             col_we;
    logic [IN_LEN-1:0][1:0]        col_code;

    assign in_ready  = (state != S_DRAIN);
    assign out_valid = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign bpr     = (n_in + CNT_W'(7)) >> 3;
    assign req_out = {1'b0, in_word[11:8]} + CNT_W'(1);
    assign req_in  = {1'b0, in_word[7:4]} + CNT_W'(1);
    assign clear   = (state == S_IDLE) && in_xfer && (in_word[15:12] == OP_CLEAR);
    assign first   = (col == '0);
    // Odd n_in: the upper byte of the last beat falls outside the active columns.
    assign x1_en   = (col + CNT_W'(1)) < n_in;

    for (genvar c = 0; c < IN_LEN; c++) begin : g_col
        assign col_we[c]   = (CNT_W'(c / 8) == beat) && (CNT_W'(c) < n_in);
        assign col_code[c] = in_word[2*(c%8) +: 2];
    end

    for (genvar r = 0; r < OUT_LEN; r++) begin : g_lane
        assign load_en[r] = (state == S_LOAD) && in_xfer && (row == CNT_W'(r));
        assign mult_en[r] = (state == S_MULT) && in_xfer && (CNT_W'(r) < n_out);

        ternary_acc_lane #(.IN_LEN(IN_LEN), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .load_en  (load_en[r]),
            .col_we   (col_we),
            .col_code (col_code),
            .mult_en  (mult_en[r]),
            .first    (first),
            .col      (col),
            .x0       (in_word[7:0]),
            .x1       (in_word[15:8]),
            .x1_en    (x1_en),
            .data     (lane_data[r]),
            .sat      (lane_sat[r])
        );
    end

    always_comb begin
        sel_data = '0;
        sel_sat  = 1'b0;
        for (int r = 0; r < OUT_LEN; r++) begin
            if (idx == CNT_W'(r)) begin
                sel_data = lane_data[r];
                sel_sat  = lane_sat[r];
            end
        end
    end

    assign out_data = out_valid ? sel_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n_out     <= OUT_MAX;
            n_in      <= IN_MAX;
            n_vec     <= '0;
            row       <= '0;
            beat      <= '0;
            col       <= '0;
            idx       <= '0;
            auto_mult <= 1'b0;
            redrain   <= 1'b0;
            err       <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_xfer) begin
                    case (in_word[15:12])
                        OP_LOAD: begin
                            if (req_out > OUT_MAX) begin
                                n_out <= OUT_MAX;
                                err   <= 1'b1;
                            end else n_out <= req_out;
                            if (req_in > IN_MAX) begin
                                n_in <= IN_MAX;
                                err  <= 1'b1;
                            end else n_in <= req_in;
                            auto_mult <= in_word[0];
                            row       <= '0;
                            beat      <= '0;
                            state     <= S_LOAD;
                        end
                        OP_MULT: begin
                            n_vec <= {1'b0, in_word[7:0]} + 9'd1;
                            col   <= '0;
                            state <= S_MULT;
                        end
                        OP_REDRAIN: begin
                            redrain <= 1'b1;
                            idx     <= '0;
                            state   <= S_DRAIN;
                        end
                        OP_CLEAR: begin
                            err      <= 1'b0;
                            sat_flag <= 1'b0;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                S_LOAD: if (in_xfer) begin
                    if (beat == bpr - CNT_W'(1)) begin
                        beat <= '0;
                        if (row == n_out - CNT_W'(1)) begin
                            row <= '0;
                            if (auto_mult) begin
                                n_vec <= 9'd1;
                                col   <= '0;
                                state <= S_MULT;
                            end else state <= S_IDLE;
                        end else row <= row + CNT_W'(1);
                    end else beat <= beat + CNT_W'(1);
                end
                S_MULT: if (in_xfer) begin
                    if (col + CNT_W'(2) >= n_in) begin
                        col     <= '0;
                        idx     <= '0;
                        redrain <= 1'b0;
                        state   <= S_DRAIN;
                    end else col <= col + CNT_W'(2);
                end
                S_DRAIN: if (out_xfer) begin
                    if (sel_sat) sat_flag <= 1'b1;
                    if (idx == n_out - CNT_W'(1)) begin
                        idx <= '0;
                        if (!redrain) n_vec <= n_vec - 9'd1;
                        if (!redrain && n_vec > 9'd1) begin
                            col   <= '0;
                            state <= S_MULT;
                        end else state <= S_IDLE;
                    end else idx <= idx + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Self-checking bench: transaction-level model of the command stream, per-cycle output compare.
module tb_ternary_mvm_engine;
    import ternary_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        in_ready, out_valid, busy, err, sat_flag;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;

    ternary_mvm_engine #(.IN_LEN(16), .OUT_LEN(8), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .err(err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Model state: mode 0=command, 1=loading weights, 2=taking activations.
    int mw[8][16];
    int macc[8];
    int mx[16];
    int m_nout, m_nin, m_auto, m_vec, m_beat, m_mode;
    bit m_err, m_sat;
    int exp_q[$];
    logic [7:0] got_q[$];
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        if (v > 127)  return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic int wval(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b11) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            macc[r] = 0;
            for (int c = 0; c < 16; c++) mw[r][c] = 0;
        end
        m_nout = 8; m_nin = 16; m_auto = 0; m_vec = 0; m_beat = 0; m_mode = 0;
        m_err = 0; m_sat = 0;
        exp_q.delete();
    endtask

    task automatic model_word(input logic [15:0] w);
        int bpr, rw, blk, c;
        case (m_mode)
            0: begin
                case (w[15:12])
                    OP_LOAD: begin
                        m_nout = int'(w[11:8]) + 1;
                        if (m_nout > 8) begin m_nout = 8; m_err = 1; end
                        m_nin = int'(w[7:4]) + 1;
                        m_auto = int'(w[0]);
                        m_beat = 0;
                        m_mode = 1;
                    end
                    OP_MULT: begin
                        m_vec = int'(w[7:0]) + 1;
                        m_beat = 0;
                        m_mode = 2;
                    end
                    OP_REDRAIN: for (int r = 0; r < m_nout; r++) exp_q.push_back(macc[r]);
                    OP_CLEAR: begin
                        for (int r = 0; r < 8; r++) begin
                            macc[r] = 0;
                            for (int k = 0; k < 16; k++) mw[r][k] = 0;
                        end
                        m_err = 0; m_sat = 0;
                    end
                    default: m_err = 1;
                endcase
            end
            1: begin
                bpr = (m_nin + 7) / 8;
                rw  = m_beat / bpr;
                blk = m_beat % bpr;
                for (int k = 0; k < 8; k++) begin
                    c = blk * 8 + k;
                    if (c < m_nin) mw[rw][c] = wval(w[2*k +: 2]);
                end
                m_beat++;
                if (m_beat == m_nout * bpr) begin
                    m_beat = 0;
                    if (m_auto != 0) begin m_vec = 1; m_mode = 2; end
                    else m_mode = 0;
                end
            end
            default: begin
                mx[2*m_beat]     = int'($signed(w[7:0]));
                mx[2*m_beat + 1] = int'($signed(w[15:8]));
                m_beat++;
                if (2 * m_beat >= m_nin) begin
                    for (int r = 0; r < m_nout; r++) begin
                        macc[r] = 0;
                        for (int k = 0; k < m_nin; k++) macc[r] += mw[r][k] * mx[k];
                        exp_q.push_back(macc[r]);
                    end
                    m_vec--;
                    m_beat = 0;
                    m_mode = (m_vec > 0) ? 2 : 0;
                end
            end
        endcase
    endtask

    // Called at posedge+1; transfers on the first edge where in_ready is high.
    task automatic send_word(input logic [15:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1 for word %h", w);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        model_word(w);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && m_mode == 0 && !busy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got busy=%0d expected 0", busy);
        end
        @(posedge clk); #1;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            bit ev;
            ev = (exp_q.size() != 0);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, !ev);
            chk("busy", busy, (m_mode != 0) || ev);
            chk("err", err, m_err);
            chk("sat_flag", sat_flag, m_sat);
            if (out_valid && ev) begin
                chk("out_data", out_data, sat8(exp_q[0]));
                if (out_ready) begin
                    got_q.push_back(out_data);
                    if (exp_q[0] > 127 || exp_q[0] < -128) m_sat = 1;
                    void'(exp_q.pop_front());
                end
            end else if (!out_valid) begin
                chk("out_data_idle", out_data, 8'h00);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int base;
        logic [7:0] held;
        logic [3:0] op;
        logic [15:0] cmd;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst err", err, 0);
        chk("rst sat_flag", sat_flag, 0);
        chk("rst out_data", out_data, 0);
        @(posedge clk); #1;

        // Basic run
        base = got_q.size();
        send_word(16'hA130); send_word(16'h0055); send_word(16'h00FF);
        send_word(16'hF000); send_word(16'h0201); send_word(16'h0403);
        wait_idle();
        chk("basic count", got_q.size() - base, 2);
        chk("basic row0", got_q[base], 8'h0A);
        chk("basic row1", got_q[base+1], 8'hF6);
        chk("basic err", err, 0);

        // Saturation with auto-MULT
        send_word(16'hA0F1); send_word(16'h5555); send_word(16'h5555);
        repeat (8) send_word(16'h7F7F);
        wait_idle();
        chk("sat row0", got_q[$], 8'h7F);
        chk("sat flag set", sat_flag, 1);

        // Backpressure across a two-vector run
        base = got_q.size();
        send_word(16'hA330);
        send_word(16'h0055); send_word(16'h00FF); send_word(16'h0005); send_word(16'h0030);
        send_word(16'hF001);
        fork
            begin
                send_word(16'h0201); send_word(16'h0403);
                send_word(16'h8080); send_word(16'h7F7F);
            end
            begin
                for (int t = 0; t < 200 && got_q.size() < base + 2; t++) @(negedge clk);
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                for (int t = 0; t < 3; t++) begin
                    chk("stall hold", out_data, held);
                    chk("stall in_ready", in_ready, 0);
                    chk("stall out_valid", out_valid, 1);
                    @(negedge clk);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp count", got_q.size() - base, 8);
        chk("bp v1r0", got_q[base],   8'h0A);
        chk("bp v1r1", got_q[base+1], 8'hF6);
        chk("bp v1r2", got_q[base+2], 8'h03);
        chk("bp v1r3", got_q[base+3], 8'hFD);
        chk("bp v2r0", got_q[base+4], 8'hFE);
        chk("bp v2r1", got_q[base+5], 8'h02);
        chk("bp v2r2", got_q[base+6], 8'h80);
        chk("bp v2r3", got_q[base+7], 8'h81);

        // Clamp, bad opcode, clear
        send_word(16'hAF00);
        repeat (8) send_word(16'h0001);
        @(negedge clk); chk("clamp err", err, 1); @(posedge clk); #1;
        send_word(16'h3000);
        @(negedge clk); chk("badop err", err, 1); @(posedge clk); #1;
        send_word(16'h5000);
        @(negedge clk);
        chk("clear err", err, 0);
        chk("clear sat", sat_flag, 0);
        @(posedge clk); #1;
        base = got_q.size();
        send_word(16'hF000); send_word(16'h0005);
        wait_idle();
        send_word(16'hB000);
        wait_idle();
        chk("clear count", got_q.size() - base, 16);
        for (int i = 0; i < 16; i++) chk("clear zero", got_q[base+i], 0);

        // Reset in the middle of MULT
        send_word(16'hA130); send_word(16'h0055); send_word(16'h00FF);
        send_word(16'hF000); send_word(16'h0201);
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst busy", busy, 0);
        @(posedge clk); #1;
        base = got_q.size();
        send_word(16'hB000);
        wait_idle();
        chk("midrst count", got_q.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("midrst zero", got_q[base+i], 0);

        // Randomized command streams with random backpressure
        rand_ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) send_word(16'h5000);
            else if (sel == 1) begin
                op = 4'($urandom_range(0, 15));
                if (op == OP_LOAD || op == OP_MULT || op == OP_REDRAIN || op == OP_CLEAR) op = 4'h0;
                send_word({op, 12'($urandom)});
            end
            else if (sel == 2) send_word(16'hB000);
            else begin
                cmd = {OP_LOAD, 4'($urandom), 4'($urandom), 3'b000, 1'($urandom)};
                send_word(cmd);
                for (int k = 0; k < 40 && m_mode == 1; k++) send_word(16'($urandom));
                if (m_mode == 0) send_word({OP_MULT, 4'h0, 8'($urandom_range(0, 2))});
                for (int k = 0; k < 40 && m_mode == 2; k++) send_word(16'($urandom));
            end
            wait_idle();
        end
        rand_ready = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ternary_mvm_engine.md
Name: ternary_mvm_engine

Overview:
Command-driven ternary matrix-vector engine. Next generation of the chip-top IDLE/LOAD/MULT controller with its weight loader and multiplier.
- Adds runtime-configurable active rows/cols, a valid/ready stream on both sides, multi-vector runs, saturating readout, re-drain and sticky status.
- Sits between the 16-bit pin bus and the 8-bit output pins of the tapeout top.

Parameters:
IN_LEN, 16, max input columns (2..16)
OUT_LEN, 8, max output rows (1..16)
OUT_W, 8, output result width (signed, saturated)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  in_word valid
in_word  in  16  command or data word
in_ready  out  1  engine accepts in_word (xfer = in_valid & in_ready)
out_valid  out  1  out_data valid
out_data  out  OUT_W  saturated result for current row
out_ready  in  1  consumer accepts out_data
busy  out  1  state != IDLE
err  out  1  sticky config/opcode error
sat_flag  out  1  sticky saturation seen

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset: state=IDLE; weights all 0; accumulators 0; n_out=OUT_LEN; n_in=IN_LEN; err=sat_flag=0; out_valid=0; busy=0; in_ready=1; out_data=0. Reset mid-operation aborts immediately with the same values.
- Weight code (2 bits): 00=0, 01=+1, 11=-1, 10=reserved, treated as 0.
- States: IDLE, LOAD, MULT, DRAIN. in_ready=1 in IDLE/LOAD/MULT, 0 in DRAIN.
- IDLE: the opcode is in_word[15:12], decoded on xfer.
  - 0xA LOAD: n_out=in_word[11:8]+1, n_in=in_word[7:4]+1, each clamped to OUT_LEN/IN_LEN. A clamp sets err. auto=in_word[0]. Go to LOAD.
  - 0xF MULT: n_vec=in_word[7:0]+1. Go to MULT.
  - 0xB REDRAIN: go to DRAIN, re-emitting the current accumulators.
  - 0x5 CLEAR: in one cycle, zero weights and accumulators, clear err and sat_flag. Stay in IDLE.
  - Any other opcode: ignored, err=1.
- LOAD:
  - beats_per_row=ceil(n_in/8); total = n_out*beats_per_row. Rows are loaded in order, beats within a row in ascending column order.
  - Beat bits [2k+1:2k] hold the weight for column base+k. Columns >= n_in are ignored.
  - Unwritten weights keep their previous value.
  - After the final beat: go to MULT with n_vec=1 if auto=1, else go to IDLE.
- MULT:
  - Each beat carries two signed int8 activations: x[j]=in_word[7:0], x[j+1]=in_word[15:8]. beats = ceil(n_in/2). For odd n_in, the upper byte of the last beat is ignored.
  - On each beat, all rows r<n_out update in parallel: acc[r] = (first beat ? 0 : acc[r]) + w[r][j]*x[j] + w[r][j+1]*x[j+1].
  - Internal accumulator width = 8+$clog2(IN_LEN)+1. It never overflows.
  - After the last beat, go to DRAIN next cycle with final accumulators.
- DRAIN:
  - out_valid=1 for every cycle in DRAIN.
  - out_data = sat(acc[idx]), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; combinational from the idx register.
  - sat_flag is set when a clamped value is transferred.
  - idx advances on out_valid&out_ready. While out_ready=0, out_data and idx hold.
  - After row n_out-1 transfers: decrement n_vec. If vectors remain, go to MULT; otherwise go to IDLE. REDRAIN always returns to IDLE.
- Rows >= n_out are never emitted. Accumulators are retained after DRAIN.
- Latency: last MULT beat at edge k -> out_valid=1 in the cycle after edge k -> throughput of 1 result/cycle with out_ready=1.

Decomposition:
- Package ternary_pkg:
  - opcode constants OP_LOAD=4'hA, OP_MULT=4'hF, OP_REDRAIN=4'hB, OP_CLEAR=4'h5
  - state enum
  - weight encodings W_ZERO/W_POS/W_NEG
  - ACT_W=8
  - acc-width function
- Sub-module ternary_acc_lane, instantiated OUT_LEN times. Each lane holds one row's weights, its accumulator, its two-term ternary update, and its saturation logic.

Test Plan:
- Reset, then idle -> out_valid=0, busy=0, in_ready=1, err=0, sat_flag=0, out_data=0.
- Basic run: LOAD 0xA130 (n_out=2, n_in=4), weights 0x0055, 0x00FF; MULT 0xF000; data 0x0201, 0x0403 -> out_data 0x0A then 0xF6, then IDLE, err=0.
- Saturation: LOAD 0xAF00 clamp case excluded; LOAD 0xA0F1 (n_out=1, n_in=16, auto) with weight beats 0x5555, 0x5555, then 8 beats of 0x7F7F -> out_data=0x7F, sat_flag=1.
- Backpressure plus multi-vector: MULT 0xF001 (2 vectors), out_ready low 3 cycles mid-DRAIN -> out_data/idx held, in_ready=0; second vector is accepted only after the first drain completes.
- Clamp and clear: LOAD 0xAF00 -> n_out=8, err=1; opcode 0x3 -> err stays 1; CLEAR 0x5000 -> err=0, sat_flag=0; MULT, REDRAIN -> all outputs 0.
- Reset mid-MULT: rst_n low for 1 cycle after beat 1 of 2 -> IDLE, out_valid=0, weights and accumulators 0; REDRAIN emits 0.
